cart_upload_reader: RTL



---
 rtl/cart_upload_reader_pkg.sv | 14 +
 rtl/cart_upload_reader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cart_upload_reader_pkg.sv
// Shared definitions for the cartridge upload (HPS readback) path:
// reader state encoding, default fill byte and the supported RAM latency ceiling.
package vectrex_upload_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAITQ = 2'd2
  } upload_state_t;

  localparam logic [7:0] FILL_DEFAULT    = 8'hFF;
  localparam int         RAM_LATENCY_MAX = 4;

endpackage

// File: rtl/cart_upload_reader.sv
// Answers HPS ioctl_rd strobes during an upload by fetching bytes from the cart RAM
// read port. Optional running checksum output is built when UPLOAD_CHECKSUM_EN is defined.
module cart_upload_reader
  import vectrex_upload_pkg::*;
#(
  parameter int         ADDR_W      = 15,
  parameter int         RAM_LATENCY = 2,
  parameter logic [7:0] FILL        = FILL_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic [ADDR_W-1:0] cart_mask,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       bytes_sent
`ifdef UPLOAD_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int CNT_W = $clog2(RAM_LATENCY_MAX);

  upload_state_t     r_state, w_state_nxt;
  logic [7:0]        r_din, w_din_nxt;
  logic              r_wait, w_wait_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic              r_ram_rd, w_ram_rd_nxt;
  logic              r_busy;
  logic              r_overrun, w_overrun_nxt;
  logic [15:0]       r_bytes, w_bytes_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_req, w_rise, w_in_range, w_deliver;
  logic [7:0]        w_byte;
  logic [15:0]       w_bytes_base;

  // Address must lie inside the 25-bit window's cart region and under the loaded image mask
  assign w_in_range = ((ioctl_addr >> ADDR_W) == 25'd0) &&
                      ((ioctl_addr[ADDR_W-1:0] & ~cart_mask) == '0);
  assign w_req      = ioctl_rd & ioctl_upload;
  assign w_rise     = ioctl_upload & ~r_busy;

  always_comb begin
    w_state_nxt    = r_state;
    w_din_nxt      = r_din;
    w_wait_nxt     = r_wait;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_rd_nxt   = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_overrun_nxt  = w_rise ? 1'b0 : r_overrun;
    w_deliver      = 1'b0;
    w_byte         = r_din;

    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_in_range) begin
            w_ram_addr_nxt = ioctl_addr[ADDR_W-1:0];
            w_ram_rd_nxt   = 1'b1;
            w_wait_nxt     = 1'b1;
            w_state_nxt    = ISSUE;
          end else begin
            w_deliver = 1'b1;
            w_byte    = FILL;
          end
        end
      end
      ISSUE: begin
        if (!ioctl_upload) begin
          w_state_nxt = IDLE;
          w_wait_nxt  = 1'b0;
        end else begin
          if (w_req) w_overrun_nxt = 1'b1;
          w_cnt_nxt   = CNT_W'(RAM_LATENCY - 1);
          w_state_nxt = WAITQ;
        end
      end
      WAITQ: begin
        if (!ioctl_upload) begin
          w_state_nxt = IDLE;
          w_wait_nxt  = 1'b0;
        end else begin
          if (w_req) w_overrun_nxt = 1'b1;
          if (r_cnt == '0) begin
            w_deliver   = 1'b1;
            w_byte      = ram_q;
            w_wait_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wait_nxt  = 1'b0;
      end
    endcase

    if (w_deliver) w_din_nxt = w_byte;

    // A new session clears the count before any byte delivered in the same cycle is added
    w_bytes_base = w_rise ? 16'd0 : r_bytes;
    w_bytes_nxt  = w_bytes_base;
    if (w_deliver && (w_bytes_base != 16'hFFFF)) w_bytes_nxt = w_bytes_base + 16'd1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_din      <= 8'h00;
      r_wait     <= 1'b0;
      r_ram_addr <= '0;
      r_ram_rd   <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_bytes    <= 16'd0;
      r_cnt      <= '0;
    end else begin
      r_din      <= w_din_nxt;
      r_wait     <= w_wait_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_rd   <= w_ram_rd_nxt;
      r_busy     <= ioctl_upload;
      r_overrun  <= w_overrun_nxt;
      r_bytes    <= w_bytes_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] r_checksum, w_checksum_base;

  assign w_checksum_base = w_rise ? 8'h00 : r_checksum;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)          r_checksum <= 8'h00;
    else if (w_deliver) r_checksum <= w_checksum_base + w_byte;
    else                r_checksum <= w_checksum_base;
  end

  assign checksum = r_checksum;
`endif

  assign ioctl_din  = r_din;
  assign ioctl_wait = r_wait;
  assign ram_addr   = r_ram_addr;
  assign ram_rd     = r_ram_rd;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign bytes_sent = r_bytes;

endmodule
